// File: rtl/sha3_absorber_if.sv
// rtl/sha3_absorber_if.sv - lane stream, permutation feedback and working-state bundle for sha3_absorber
interface sha3_absorber_if;
  logic [63:0]      in_lane;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [4:0][63:0] fba, fbb, fbc, fbd, fbe;
  logic             fb_good;
  logic [4:0][63:0] osa, osb, osc, osd, ose;
  logic             sample;
  logic             done;
  logic             clear;

  modport master (
    output in_lane, in_valid, in_last, fba, fbb, fbc, fbd, fbe, fb_good, clear,
    input  in_ready, osa, osb, osc, osd, ose, sample, done
  );

  modport slave (
    input  in_lane, in_valid, in_last, fba, fbb, fbc, fbd, fbe, fb_good, clear,
    output in_ready, osa, osb, osc, osd, ose, sample, done
  );
endinterface

// File: rtl/sha3_absorber.sv
// rtl/sha3_absorber.sv - XORs padded message lanes into the 1600-bit state and hands blocks to the permutation
module sha3_absorber #(
  parameter int RATE_LANES = 17
) (
  input  logic            clk,
  input  logic            rst,
  sha3_absorber_if.slave  bus
);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DONE} state_e;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  state_e            st_q;
  logic [24:0][63:0] state_q;
  logic [4:0]        cnt_q;
  logic              last_q;
  logic              sample_q;
  logic              done_q;

  // Lane k lives in row k/5, column k%5; rows are consecutive groups of five lanes.
  assign bus.osa      = state_q[4:0];
  assign bus.osb      = state_q[9:5];
  assign bus.osc      = state_q[14:10];
  assign bus.osd      = state_q[19:15];
  assign bus.ose      = state_q[24:20];
  assign bus.sample   = sample_q;
  assign bus.done     = done_q;
  assign bus.in_ready = (st_q == FILL) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= FILL;
      state_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      case (st_q)
        FILL: begin
          if (bus.in_valid) begin
            state_q[cnt_q] <= state_q[cnt_q] ^ bus.in_lane;
            last_q         <= last_q | bus.in_last;
            if (cnt_q == LAST_IDX) begin
              cnt_q    <= '0;
              st_q     <= ISSUE;
              sample_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ISSUE: st_q <= WAIT;
        WAIT: begin
          // Feedback takes priority; clear has no meaning until DONE.
          if (bus.fb_good) begin
            state_q <= {bus.fbe, bus.fbd, bus.fbc, bus.fbb, bus.fba};
            if (last_q) begin
              last_q <= 1'b0;
              st_q   <= DONE;
              done_q <= 1'b1;
            end else begin
              st_q <= FILL;
            end
          end
        end
        DONE: begin
          if (bus.clear) begin
            state_q <= '0;
            st_q    <= FILL;
            done_q  <= 1'b0;
          end
        end
        default: st_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorber.sv
// tb/tb_sha3_absorber.sv - directed self-checking bench for sha3_absorber
module tb_sha3_absorber;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha3_absorber_if bus_a ();
  sha3_absorber_if bus_b ();

  sha3_absorber #(.RATE_LANES(17)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sha3_absorber #(.RATE_LANES(9))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int samp_cnt = 0;

  localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  always @(posedge clk) begin
    if (bus_a.in_valid && bus_a.in_ready) hs_cnt = hs_cnt + 1;
    if (bus_a.sample) samp_cnt = samp_cnt + 1;
  end

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fb(input logic [63:0] v);
    bus_a.fba = {5{v}};
    bus_a.fbb = {5{v}};
    bus_a.fbc = {5{v}};
    bus_a.fbd = {5{v}};
    bus_a.fbe = {5{v}};
  endtask

  task automatic send_a(input logic [63:0] lane, input logic last, input bit rnd);
    int n = 0;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1 && n < 4) begin
        bus_a.in_valid = 1'b0;
        step();
        n++;
      end
    end
    bus_a.in_lane  = lane;
    bus_a.in_last  = last;
    bus_a.in_valid = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("send_timeout", 320'(0), 320'(1));
    step();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic feed_counting_block();
    for (int k = 0; k < 17; k++) send_a(64'(k + 1), 1'b1, 1'b0);
  endtask

  task automatic finish_block(input logic [63:0] v);
    step();
    set_fb(v);
    bus_a.fb_good = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_a.clear = 1'b1;
    step();
    bus_a.clear = 1'b0;
  endtask

  initial begin
    int s0;
    int h0;
    int n;
    logic [24:0][63:0] exp_st;

    bus_a.in_lane = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_a.fb_good = 1'b0; bus_a.clear = 1'b0;
    bus_b.in_lane = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_b.fb_good = 1'b0; bus_b.clear = 1'b0;
    bus_b.fba = '0; bus_b.fbb = '0; bus_b.fbc = '0; bus_b.fbd = '0; bus_b.fbe = '0;
    set_fb('0);

    // Scenario 1: reset, single counting block
    step();
    step();
    check("rst_in_ready", 320'(bus_a.in_ready), 320'(0));
    check("rst_sample",   320'(bus_a.sample),   320'(0));
    check("rst_done",     320'(bus_a.done),     320'(0));
    check("rst_osa",      bus_a.osa,            320'(0));
    rst = 1'b0;
    step();
    check("fill_in_ready", 320'(bus_a.in_ready), 320'(1));
    s0 = samp_cnt;
    feed_counting_block();
    check("s1_sample",    320'(bus_a.sample), 320'(1));
    check("s1_early_cnt", 320'(samp_cnt - s0), 320'(0));
    check("s1_osa", bus_a.osa, {64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
    check("s1_osd", bus_a.osd, {64'd0, 64'd0, 64'd0, 64'd17, 64'd16});
    check("s1_ose", bus_a.ose, 320'(0));
    step();
    check("s1_sample_low", 320'(bus_a.sample), 320'(0));
    check("s1_wait_ready", 320'(bus_a.in_ready), 320'(0));
    step();
    check("s1_one_pulse", 320'(samp_cnt - s0), 320'(1));

    // Scenario 2: final feedback, hold, fb outside WAIT, clear
    set_fb(A5);
    bus_a.fb_good = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
    check("s2_done",  320'(bus_a.done),     320'(1));
    check("s2_ready", 320'(bus_a.in_ready), 320'(0));
    check("s2_osa", bus_a.osa, {5{A5}});
    check("s2_osb", bus_a.osb, {5{A5}});
    check("s2_osc", bus_a.osc, {5{A5}});
    check("s2_osd", bus_a.osd, {5{A5}});
    check("s2_ose", bus_a.ose, {5{A5}});
    set_fb(64'h5A);
    bus_a.fb_good = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
    check("s2_fb_ignored", bus_a.osc, {5{A5}});
    check("s2_done_hold",  320'(bus_a.done), 320'(1));
    pulse_clear();
    check("s2_clr_done",  320'(bus_a.done),     320'(0));
    check("s2_clr_ready", 320'(bus_a.in_ready), 320'(1));
    check("s2_clr_osa",   bus_a.osa, 320'(0));
    check("s2_clr_ose",   bus_a.ose, 320'(0));

    // Scenario 3: two-block message, simultaneous fb_good+clear in WAIT
    for (int k = 0; k < 17; k++) send_a(64'(k * 3), 1'b0, 1'b0);
    step();
    set_fb('0);
    bus_a.fba[0]  = 64'hFF;
    bus_a.fb_good = 1'b1;
    bus_a.clear   = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
    bus_a.clear   = 1'b0;
    check("s3_b0_no_done", 320'(bus_a.done),     320'(0));
    check("s3_b0_ready",   320'(bus_a.in_ready), 320'(1));
    check("s3_b0_osa",     bus_a.osa, {64'd0, 64'd0, 64'd0, 64'd0, 64'hFF});
    send_a(64'h0F, 1'b1, 1'b0);
    for (int k = 1; k < 17; k++) send_a(64'd0, 1'b0, 1'b0);
    check("s3_b1_sample", 320'(bus_a.sample), 320'(1));
    check("s3_b1_lane0",  320'(bus_a.osa[0]), 320'(64'hF0));
    finish_block('0);
    check("s3_b1_done", 320'(bus_a.done), 320'(1));
    pulse_clear();

    // Scenario 4: random in_valid gaps, held lane during ISSUE/WAIT
    h0 = hs_cnt;
    s0 = samp_cnt;
    for (int k = 0; k < 17; k++) begin
      exp_st[k] = 64'(100 + k);
      send_a(64'(100 + k), 1'b0, 1'b1);
      if (k < 16) check("s4_no_early_sample", 320'(samp_cnt - s0), 320'(0));
    end
    for (int k = 17; k < 25; k++) exp_st[k] = '0;
    check("s4_hs",     320'(hs_cnt - h0), 320'(17));
    check("s4_sample", 320'(bus_a.sample), 320'(1));
    check("s4_osa", bus_a.osa, exp_st[4:0]);
    check("s4_osb", bus_a.osb, exp_st[9:5]);
    check("s4_osc", bus_a.osc, exp_st[14:10]);
    check("s4_osd", bus_a.osd, exp_st[19:15]);
    check("s4_ose", bus_a.ose, exp_st[24:20]);
    bus_a.in_lane  = 64'hDEAD;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("s4_ready_low", 320'(bus_a.in_ready), 320'(0));
      step();
    end
    bus_a.in_valid = 1'b0;
    check("s4_hs_held", 320'(hs_cnt - h0), 320'(17));
    set_fb('0);
    bus_a.fb_good = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
    check("s4_refill", 320'(bus_a.in_ready), 320'(1));

    // Scenario 5: clear in FILL ignored, reset mid-block, stale feedback ignored
    for (int k = 0; k < 8; k++) send_a(64'(k + 1), 1'b1, 1'b0);
    pulse_clear();
    check("s5_clear_ignored", 320'(bus_a.osa[0]), 320'(1));
    #2 rst = 1'b1;
    #1;
    check("s5_rst_osa",   bus_a.osa, 320'(0));
    check("s5_rst_osb",   bus_a.osb, 320'(0));
    check("s5_rst_ready", 320'(bus_a.in_ready), 320'(0));
    check("s5_rst_flags", 320'({bus_a.sample, bus_a.done}), 320'(0));
    step();
    step();
    rst = 1'b0;
    s0 = samp_cnt;
    set_fb(A5);
    bus_a.fb_good = 1'b1;
    step();
    bus_a.fb_good = 1'b0;
    check("s5_fb_ignored", bus_a.osa, 320'(0));
    check("s5_no_sample",  320'(samp_cnt - s0), 320'(0));
    feed_counting_block();
    check("s5_sample", 320'(bus_a.sample), 320'(1));
    check("s5_osa", bus_a.osa, {64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
    check("s5_osd", bus_a.osd, {64'd0, 64'd0, 64'd0, 64'd17, 64'd16});
    finish_block(A5);
    check("s5_done", 320'(bus_a.done), 320'(1));
    pulse_clear();

    // Scenario 6: nine-lane rate instance
    for (int k = 0; k < 9; k++) begin
      bus_b.in_lane  = 64'd1;
      bus_b.in_last  = 1'b1;
      bus_b.in_valid = 1'b1;
      n = 0;
      while (!bus_b.in_ready && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) check("s6_timeout", 320'(0), 320'(1));
      if (k < 8) begin
        step();
        check("s6_no_early_sample", 320'(bus_b.sample), 320'(0));
      end else begin
        step();
      end
    end
    bus_b.in_valid = 1'b0;
    check("s6_sample", 320'(bus_b.sample), 320'(1));
    check("s6_osa", bus_b.osa, {5{64'd1}});
    check("s6_osb", bus_b.osb, {64'd0, 64'd1, 64'd1, 64'd1, 64'd1});
    check("s6_osc", bus_b.osc, 320'(0));
    step();
    check("s6_wait_ready", 320'(bus_b.in_ready), 320'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_absorber.md
Name: sha3_absorber

Overview:
Upstream feeder of the theta stage. Accepts a message as a stream of 64-bit lanes, which must already be padded. It XORs each lane into a 1600-bit working state and issues the state to the permutation pipeline with a one-cycle sample pulse. It then waits for the permuted state to return before absorbing the next block. After the final block it holds the digest state until cleared.

Parameters:
RATE_LANES, 17, lanes per block. Legal range 1..24; 17 selects SHA3-256 and 9 selects SHA3-512.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_lane  in  64  message lane, little-endian as stored in state
in_valid  in  1  in_lane valid
in_last  in  1  lane belongs to the final block of the message
in_ready  out  1  block accepts a lane this cycle
fba, fbb, fbc, fbd, fbe  in  64 x5 each  permuted state returned from the round pipeline
fb_good  in  1  fb* valid this cycle
osa, osb, osc, osd, ose  out  64 x5 each  working state, wired to theta isa..ise
sample  out  1  one-cycle pulse: os* is a block to permute
done  out  1  final state is held on os*
clear  in  1  release done and start a new message

Behaviour:
- Lane mapping: lane k, with k = 0..24, is stored in row k/5, column k%5. Row 0 is osa, row 4 is ose. os* always reflects the working-state registers.
- Reset, asserted asynchronously: state = 0, lane counter = 0, last flag = 0, FSM = FILL, sample = 0, done = 0, in_ready = 0 while rst is high.
- FSM states: FILL, ISSUE, WAIT, DONE.
  - FILL: in_ready = 1. On a handshake (in_valid & in_ready):
    - state[cnt] ^= in_lane at the clock edge;
    - cnt increments;
    - last flag |= in_last (sticky within the block).
    - When the handshake is on lane cnt = RATE_LANES-1: cnt -> 0 and FSM -> ISSUE.
  - ISSUE: lasts exactly one cycle. sample = 1, in_ready = 0, os* = block with all lanes XORed in. FSM -> WAIT.
  - WAIT: in_ready = 0. On fb_good, capture all 25 lanes from fb* into state.
    - If the last flag is set: clear the flag and go to DONE.
    - Otherwise go to FILL.
  - DONE: done = 1, in_ready = 0, os* holds the final permuted state. On clear: state = 0, FSM -> FILL, done = 0 next cycle.
- Latency:
  - sample rises on the cycle after the edge that accepted the last lane of the block.
  - in_ready rises on the cycle after the fb_good edge.
  - done rises on the cycle after the final fb_good edge.
- Lanes at indices >= RATE_LANES are never written by input; they change only through feedback.
- Boundary conditions:
  - fb_good outside WAIT is ignored; state is unchanged.
  - clear outside DONE is ignored.
  - in_valid while in_ready = 0 is not consumed; the lane must be held by the source.
  - in_last on a non-final lane of a block still marks the whole block final. Correct padding remains the source's responsibility.
  - Simultaneous fb_good and clear in WAIT: fb_good wins and clear is ignored.
  - rst mid-block or mid-WAIT aborts the message. Everything returns to reset values and a later fb_good is ignored.
- sample and done are registered outputs, with no combinational path from inputs. in_ready is a decode of FSM state only.

Test Plan:
1. Reset, then feed 17 lanes with in_lane = k+1 (k = 0..16) and in_last = 1 on all lanes. Required: sample pulses exactly once, 1 cycle after the 17th handshake. osa = {1,2,3,4,5}, osd[1] = 17, osd[2..4] = 0, ose = 0.
2. Continue from scenario 1. Return fb* = all lanes 64'hA5A5_A5A5_A5A5_A5A5 with fb_good. Required: done = 1 next cycle, os* = all A5, in_ready = 0. Pulse clear: state = 0, in_ready = 1 on the following cycle.
3. Two-block message: block 0 with in_last = 0, feedback with lane 0 = 64'hFF, then block 1 with lane 0 = 64'h0F and in_last = 1. Required: block 1 sample shows osa[0] = 64'hF0, and done follows the second fb_good only.
4. Toggle in_valid randomly (50%) during the fill. Required: exactly 17 handshakes before sample, accepted lanes in order, and in_ready = 0 throughout ISSUE and WAIT.
5. Assert rst after 8 accepted lanes, then fb_good after release. Required: all outputs 0, no sample, and fb ignored. A fresh 17-lane block then behaves as in scenario 1.
6. With RATE_LANES = 9, feed 9 lanes of 64'h1. Required: sample after the 9th handshake, osa = 5x 1, osb[0..3] = 1, osb[4] = 0.
